draw_port_arbiter: RTL and testbench

- Shares the single VGA plot port (x, y, colour, plot) between three pixel writers: rocket drawer (requester 0), asteroid drawer (requester 1) and laser drawer (requester 2).
- Round-robin arbitration with bounded bursts, so no writer can starve another while objects move or are erased.
- Sits between the object draw units, which the collision and motion controllers sequence, and the VGA adapter.

---
 rtl/draw_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_draw_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter
//   Shares the single VGA plot port between three pixel writers: rocket
//   drawer (requester 0), asteroid drawer (requester 1) and laser drawer
//   (requester 2). Round-robin arbitration with bursts bounded by MAX_BURST
//   while another writer is waiting. One idle cycle separates bursts.
//
//   Optional build macro: LASER_PRIORITY_EN
//     defined   - laser (requester 2) wins every idle-cycle arbitration and
//                 pre-empts any other owner after its current accept.
//     undefined - pure round-robin.
//
// Ports
//   clock                  system clock, rising edge
//   reset                  asynchronous active-low reset
//   req[2:0]               per-requester pixel request
//   px_x*/px_y*/px_c*      pixel x / y / colour of each requester
//   clear_stats            synchronous clear of pix_count (beats increment)
//   gnt[2:0]               one-hot accept strobe (combinational)
//   vga_x/vga_y/vga_colour registered pixel to the VGA adapter
//   plot                   registered write enable
//   owner                  current owner index, 3 = none
//   busy                   high while a grant is active
//   pix_count              saturating count of plotted pixels
module draw_port_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int COLOUR_W  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [7:0]          px_x0,
  input  logic [7:0]          px_x1,
  input  logic [7:0]          px_x2,
  input  logic [6:0]          px_y0,
  input  logic [6:0]          px_y1,
  input  logic [6:0]          px_y2,
  input  logic [COLOUR_W-1:0] px_c0,
  input  logic [COLOUR_W-1:0] px_c1,
  input  logic [COLOUR_W-1:0] px_c2,
  input  logic                clear_stats,
  output logic [2:0]          gnt,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic [1:0]          owner,
  output logic                busy,
  output logic [15:0]         pix_count
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t              state, state_nxt;
  logic [1:0]          owner_nxt, last_owner, last_owner_nxt;
  logic [7:0]          burst_cnt, burst_cnt_nxt;
  logic [2:0]          owner_oh, others;
  logic [1:0]          pick;
  logic                accept;
  logic [7:0]          sel_x;
  logic [6:0]          sel_y;
  logic [COLOUR_W-1:0] sel_c;

  // First requesting index strictly after 'last' in the cycle 0->1->2->0.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] r);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd3;
    found   = 1'b0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = 2'((32'(last) + k) % 3);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    owner_oh = (owner == 2'd3) ? 3'b000 : 3'(3'b001 << owner);
    others   = req & ~owner_oh;
    accept   = (state == S_GRANT) && |(owner_oh & req);
`ifdef LASER_PRIORITY_EN
    pick = req[2] ? 2'd2 : rr_pick(last_owner, req);
`else
    pick = rr_pick(last_owner, req);
`endif
    case (owner)
      2'd0:    begin sel_x = px_x0; sel_y = px_y0; sel_c = px_c0; end
      2'd1:    begin sel_x = px_x1; sel_y = px_y1; sel_c = px_c1; end
      default: begin sel_x = px_x2; sel_y = px_y2; sel_c = px_c2; end
    endcase
  end

  // State register plus the registered pixel path and statistics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= 2'd3;
      last_owner <= 2'd2;
      burst_cnt  <= '0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      pix_count  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      plot       <= accept;
      if (accept) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_c;
      end
      if (clear_stats)
        pix_count <= '0;
      else if (plot && pix_count != '1)
        pix_count <= pix_count + 16'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      S_IDLE: begin
        if (|req) begin
          owner_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = S_GRANT;
        end
      end
      default: begin
        if (!accept) begin
          last_owner_nxt = owner;
          owner_nxt      = 2'd3;
          state_nxt      = S_IDLE;
        end else if (burst_cnt == 8'(MAX_BURST - 1)) begin
          if (|others) begin
            last_owner_nxt = owner;
            owner_nxt      = 2'd3;
            state_nxt      = S_IDLE;
          end else begin
            burst_cnt_nxt = '0;
          end
`ifdef LASER_PRIORITY_EN
        end else if (owner != 2'd2 && req[2]) begin
          last_owner_nxt = owner;
          owner_nxt      = 2'd3;
          state_nxt      = S_IDLE;
`endif
        end else begin
          burst_cnt_nxt = burst_cnt + 8'd1;
        end
      end
    endcase
  end

  // Outputs decoded from state/owner and the live request.
  always_comb begin
    gnt  = (state == S_GRANT) ? (owner_oh & req) : 3'b000;
    busy = (state == S_GRANT);
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
module tb_draw_port_arbiter;
  localparam int MB = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    req;
  logic [7:0]    px_x0, px_x1, px_x2;
  logic [6:0]    px_y0, px_y1, px_y2;
  logic [CW-1:0] px_c0, px_c1, px_c2;
  logic          clear_stats = 1'b0;
  logic [2:0]    gnt;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [CW-1:0] vga_colour;
  logic          plot;
  logic [1:0]    owner;
  logic          busy;
  logic [15:0]   pix_count;

  draw_port_arbiter #(.MAX_BURST(MB), .COLOUR_W(CW)) dut (
    .clock(clock), .reset(reset), .req(req),
    .px_x0(px_x0), .px_x1(px_x1), .px_x2(px_x2),
    .px_y0(px_y0), .px_y1(px_y1), .px_y2(px_y2),
    .px_c0(px_c0), .px_c1(px_c1), .px_c2(px_c2),
    .clear_stats(clear_stats), .gnt(gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .owner(owner), .busy(busy), .pix_count(pix_count)
  );

  always #5 clock = ~clock;

  // Requester behaviour: pending flag plus the pixel currently offered.
  logic [2:0]    pend = 3'b000;
  logic [7:0]    rx[3];
  logic [6:0]    ry[3];
  logic [CW-1:0] rc[3];
  assign req   = pend;
  assign px_x0 = rx[0]; assign px_x1 = rx[1]; assign px_x2 = rx[2];
  assign px_y0 = ry[0]; assign px_y1 = ry[1]; assign px_y2 = ry[2];
  assign px_c0 = rc[0]; assign px_c1 = rc[1]; assign px_c2 = rc[2];

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, who owned it last, pixels taken
  // in this burst, and the expected output pixel/stat values.
  int            m_own = -1;
  int            m_last = 2;
  int            m_taken = 0;
  int            m_cnt = 0;
  bit            m_plot = 0;
  logic [7:0]    m_x = '0;
  logic [6:0]    m_y = '0;
  logic [CW-1:0] m_c = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int next_owner(input logic [2:0] r);
`ifdef LASER_PRIORITY_EN
    if (r[2]) return 2;
`endif
    for (int k = 1; k <= 3; k++)
      if (r[(m_last + k) % 3]) return (m_last + k) % 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 2; m_taken = 0; m_cnt = 0; m_plot = 0;
    m_x = '0; m_y = '0; m_c = '0;
  endtask

  task automatic new_pixel(input int i);
    rx[i] = 8'($urandom);
    ry[i] = 7'($urandom);
    rc[i] = CW'($urandom);
  endtask

  // One clock cycle, entered and left at a falling edge.
  // rnd=1: requesters behave randomly; rnd=0: requests held, x steps per accept.
  task automatic cycle(input bit do_clr, input bit rnd, input bit full);
    logic [2:0] eg;
    int         acc;
    bit         rel;
    clear_stats = do_clr;
    #3;
    eg = (m_own >= 0 && pend[m_own]) ? 3'(1 << m_own) : 3'b000;
    if (full) begin
      check("gnt", 32'(gnt), 32'(eg));
      check("owner", 32'(owner), (m_own < 0) ? 32'd3 : 32'(m_own));
      check("busy", 32'(busy), 32'(m_own >= 0));
    end
    @(posedge clock);
    if (do_clr) m_cnt = 0;
    else if (m_plot && m_cnt < 65535) m_cnt++;
    m_plot = 0;
    acc = -1;
    if (m_own < 0) begin
      if (next_owner(pend) >= 0) begin
        m_own = next_owner(pend);
        m_taken = 0;
      end
    end else if (pend[m_own]) begin
      acc = m_own;
      m_plot = 1;
      m_x = rx[m_own]; m_y = ry[m_own]; m_c = rc[m_own];
      m_taken++;
      rel = 0;
      if (m_taken == MB) begin
        if ((pend & ~(3'(1 << m_own))) != 3'b000) rel = 1;
        else m_taken = 0;
      end
`ifdef LASER_PRIORITY_EN
      else if (m_own != 2 && pend[2]) rel = 1;
`endif
      if (rel) begin m_last = m_own; m_own = -1; end
    end else begin
      m_last = m_own;
      m_own = -1;
    end
    #1;
    check("plot", 32'(plot), 32'(m_plot));
    check("pix_count", 32'(pix_count), 32'(m_cnt));
    if (full) begin
      check("vga_x", 32'(vga_x), 32'(m_x));
      check("vga_y", 32'(vga_y), 32'(m_y));
      check("vga_colour", 32'(vga_colour), 32'(m_c));
    end
    @(negedge clock);
    if (acc >= 0) begin
      if (rnd) begin
        pend[acc] = ($urandom_range(0, 3) != 0);
        new_pixel(acc);
      end else begin
        rx[acc] = rx[acc] + 8'd1;
      end
    end
    if (rnd)
      for (int i = 0; i < 3; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          new_pixel(i);
        end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_owner", 32'(owner), 32'd3);
    check("rst_pix_count", 32'(pix_count), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rx[i] = '0; ry[i] = '0; rc[i] = '0; end
    @(negedge clock);
    pulse_reset();

    // First transaction: grant one cycle after req, plot the cycle after.
    rx[0] = 8'd10; ry[0] = 7'd20; rc[0] = 3'b111; pend = 3'b001;
    repeat (3) cycle(0, 0, 1);
    check("first_pixel_count", 32'(pix_count), 32'd1);
    pend = 3'b000;
    repeat (3) cycle(0, 0, 1);

    // Two contending requesters alternate in bursts of MB.
    pend = 3'b011;
    repeat (24) cycle(0, 0, 1);
    pend = 3'b000;
    repeat (2) cycle(0, 0, 1);

    // Lone requester streams without returning to idle.
    pend = 3'b001;
    repeat (40) cycle(0, 0, 1);
    pend = 3'b000;
    repeat (2) cycle(0, 0, 1);

    // Laser arrives while requester 0 is two pixels into its burst.
    pend = 3'b001;
    repeat (3) cycle(0, 0, 1);
    pend[2] = 1'b1;
    repeat (12) cycle(0, 0, 1);
    pend = 3'b000;
    repeat (2) cycle(0, 0, 1);

    // Reset mid-burst of owner 1; next grant goes to requester 0.
    pend = 3'b010;
    repeat (3) cycle(0, 0, 1);
    pulse_reset();
    pend = 3'b011;
    repeat (4) cycle(0, 0, 1);
    check("post_reset_owner", 32'(owner), 32'd0);

    // Randomized traffic with occasional statistic clears.
    pend = 3'b000;
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 49) == 0, 1, 1);

    // Saturation: a long uninterrupted stream from requester 0.
    pend = 3'b000;
    repeat (3) cycle(0, 0, 1);
    pend = 3'b001;
    for (int n = 0; n < 65540; n++)
      cycle(0, 0, (n < 8) || (n > 65530));
    check("saturated", 32'(pix_count), 32'hFFFF);
    cycle(1, 0, 1);
    check("clear_beats_inc", 32'(pix_count), 32'd0);
    cycle(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
